// File: rtl/fetch_pc.sv
// fetch_pc: program-counter and fetch-control stage feeding the instruction memory.
// Holds the fetch PC and advances it one word per cycle. It redirects the PC on
// branch/jump, freezes it on stall, and tracks the PC and valid flag of the word
// now on the registered output of the memory.
//
// Ports:
//   clk            clock, all state updates on posedge
//   rst            synchronous active-high reset
//   stall          hold the current PC (a redirect overrides it)
//   branch         taken-branch redirect from execute (highest priority after rst)
//   branch_target  absolute word address for branch
//   jump           jump redirect from decode
//   jump_target    absolute word address for jump
//   pc             fetch PC presented to the instruction memory
//   pc_d           PC of the word currently on the memory output
//   fetch_valid    memory output word is a real fetch, not a flush bubble
//   fetch_count    valid fetches delivered      (H2BP_FETCH_PERF_EN only)
//   redirect_count redirect cycles taken        (H2BP_FETCH_PERF_EN only)
//
// Optional feature macro: H2BP_FETCH_PERF_EN enables the performance counters.

module fetch_pc #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] PC_STEP  = 32'd1
`ifdef H2BP_FETCH_PERF_EN
    ,
    parameter int unsigned CNT_W    = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch,
    input  logic [31:0]       branch_target,
    input  logic              jump,
    input  logic [31:0]       jump_target,
    output logic [31:0]       pc,
    output logic [31:0]       pc_d,
    output logic              fetch_valid
`ifdef H2BP_FETCH_PERF_EN
    ,
    output logic [CNT_W-1:0]  fetch_count,
    output logic [CNT_W-1:0]  redirect_count
`endif
);

    logic        redirect;
    logic [31:0] pc_next;

    // Next-PC selection: branch > jump > stall > sequential (rst handled in the register).
    always_comb begin
        redirect = branch || jump;
        pc_next  = pc + PC_STEP;
        if (branch) begin
            pc_next = branch_target;
        end else if (jump) begin
            pc_next = jump_target;
        end else if (stall) begin
            pc_next = pc;
        end
    end

    // PC register plus alignment tracking for the memory's registered output.
    // On a plain stall the memory re-presents the same word, so pc_d holds too.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            pc_d        <= RESET_PC;
            fetch_valid <= 1'b0;
        end else begin
            pc          <= pc_next;
            fetch_valid <= !redirect;
            if (redirect || !stall) begin
                pc_d <= pc;
            end
        end
    end

`ifdef H2BP_FETCH_PERF_EN
    // Performance counters, free-running and wrapping at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count    <= '0;
            redirect_count <= '0;
        end else begin
            if (fetch_valid && !stall) begin
                fetch_count <= fetch_count + CNT_W'(1);
            end
            if (redirect) begin
                redirect_count <= redirect_count + CNT_W'(1);
            end
        end
    end
`else
    // Performance counters absent in this build.
`endif

endmodule
